// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX/RX stages: state encoding, parity modes,
// counter sizing helper and the board-clock default bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // 100 MHz board clock at 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick at terminal count.
// Shared with the RX stage; clear restarts the period from zero.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == TERM);

  // terminal count reloads explicitly, the counter never wraps on its own
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clear || tick) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining FIFO read port 0: pops one byte when idle and
// sends start, 8 data bits LSB first, optional parity and 1-2 stop bits.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rready,
  output logic       re,
  input  logic [7:0] rdata,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  state_t     state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] bitidx, bitidx_n;
  logic       par, par_n;
  logic       tx_n;
  logic       tick, clear;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitidx_n = bitidx;
    par_n    = par;
    re       = 1'b0;
    tx_done  = 1'b0;
    tx_n     = 1'b1;
    case (state)
      ST_IDLE: begin
        re = rready & ~rst;
        if (re) begin
          shreg_n = rdata;
          par_n   = (PARITY == PARITY_ODD) ? ~^rdata : ^rdata;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          state_n  = ST_DATA;
          bitidx_n = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_n  = {1'b0, shreg[7:1]};
          bitidx_n = bitidx + 1'b1;
          if (bitidx == 3'd7) begin
            bitidx_n = '0;
            state_n  = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_n  = ST_STOP;
          bitidx_n = '0;
        end
      end
      ST_STOP: begin
        // bitidx doubles as the stop-bit counter
        if (tick) begin
          if (bitidx == 3'(STOP_BITS - 1)) begin
            tx_done = 1'b1;
            state_n = ST_IDLE;
          end else begin
            bitidx_n = bitidx + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // line level is derived from next state so the pin is a clean flop output
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shreg_n[0];
      ST_PARITY: tx_n = par_n;
      default:   tx_n = 1'b1;
    endcase
  end

  assign busy  = re | (state != ST_IDLE);
  assign clear = (state == ST_IDLE) | (state_n != state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      bitidx <= '0;
      par    <= 1'b0;
      tx     <= 1'b1;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      bitidx <= bitidx_n;
      par    <= par_n;
      tx     <= tx_n;
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Byte-serialising UART transmitter that sits directly downstream of the 8-entry byte FIFO bank and drains it through read port 0.
- Pops one byte whenever the FIFO reports readable and the transmitter is idle, then shifts it out as an 8-bit, LSB-first asynchronous serial frame with configurable parity and stop bits.
- Drives the board TX pin. The FIFO keeps its second read port for other consumers.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200 baud). Legal range 2..65535.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- rready  input  1  FIFO read-port-0 readable flag (FIFO not empty)
- re  output  1  FIFO read-port-0 pop strobe
- rdata  input  8  FIFO read-port-0 data; valid only in a cycle where re=1, may be high-Z otherwise
- tx  output  1  serial line, idles high
- busy  output  1  high from pop cycle through last stop-bit cycle
- tx_done  output  1  one-cycle pulse in the final cycle of the last stop bit

Behaviour:
- Reset: asynchronous, active-high, and dominant over everything.
  - Reset values: state=IDLE, tx=1, busy=0, tx_done=0, re=0, bit counter=0, baud counter=0, shift register=0x00.
  - re is gated combinationally with ~rst.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - re = rready (combinational, Mealy); busy = re.
  - When re=1, rdata is captured into the shift register on the same rising edge. The FIFO advances its read pointer on that edge.
  - Then go to START with baud counter = 0.
  - rdata is never sampled when re=0.
- Baud counter: counts 0..CLKS_PER_BIT-1. Its terminal count (tick) ends the current bit.
  - The counter is the only timing source.
  - Width is clog2(CLKS_PER_BIT), computed in the package function.
- START: tx=0 for CLKS_PER_BIT cycles. On tick, go to DATA with bit index = 0.
- DATA:
  - tx = shift_reg[0].
  - On tick: shift right one place and increment the index.
  - After index 7 ticks, go to PARITY if PARITY != 0, else STOP.
- PARITY:
  - tx = XOR of the captured byte for even parity, or its inverse for odd parity.
  - The parity bit is computed at capture time and held in a register.
  - Duration is CLKS_PER_BIT cycles.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done=1 in the last cycle, then go to IDLE.
- Frame timing:
  - A frame occupies exactly 1 + (10 + (PARITY!=0) + (STOP_BITS-1)) * CLKS_PER_BIT cycles, from the pop cycle to the end of the stop bits.
  - With rready continuously high, frames are back-to-back with exactly one extra idle-high cycle (the next pop cycle) between them.
- tx output: registered from the state and shift register, so it has no combinational glitches onto the pin.
- Boundary conditions:
  - rready falling mid-frame: no effect on the frame in progress.
  - rready=1 in any non-IDLE state: re stays 0, so the FIFO is never popped twice for one frame.
  - FIFO empty (rready=0) in IDLE: remain in IDLE with tx=1 indefinitely.
  - Reset mid-frame: tx returns to 1 immediately (asynchronously). The popped byte is discarded and is not re-read.
  - Baud and bit counters wrap only through explicit reloads. No free-running overflow is permitted.

Decomposition:
- Shared package `uart_pkg`:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits)
  - PARITY_NONE/EVEN/ODD constants
  - clog2 function
  - default CLKS_PER_BIT for the 100 MHz board clock
- Sub-module `uart_baud_gen`:
  - parameter CLKS_PER_BIT
  - inputs clk, rst, clear
  - output tick, a one-cycle pulse at terminal count
  - clear is asserted on every state entry
  - reused by the future RX stage that feeds the FIFO write port

Test Plan:
1. CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; rready=1 for one cycle with rdata=0xA5.
   - re high exactly that one cycle.
   - tx = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles.
   - tx_done pulses at cycle 41 after the pop edge; busy=0 afterwards.
2. Same config; rready held high with the FIFO supplying 0x00, then 0xFF.
   - Two frames of 41 cycles each, with exactly one idle-high cycle between them.
   - re pulses twice, 41 cycles apart.
3. PARITY=1 (even), rdata=0x07: parity bit = 1. PARITY=2 (odd), rdata=0x07: parity bit = 0.
   - STOP_BITS=2: stop segment = 8 cycles high; total frame = 1 + 12*4 = 49 cycles.
4. rready toggled 0/1 every cycle during a frame.
   - re stays 0 until the frame ends; the FIFO pops exactly one byte per frame.
   - rdata driven X/Z outside re cycles does not corrupt tx.
5. Assert rst asynchronously in the middle of DATA bit 3 (between clock edges).
   - tx=1 and busy=0 immediately; re=0 during reset.
   - After release with rready=1, a fresh frame of the new byte starts with a correct start bit.
6. rready=0 for 1000 cycles after reset: tx=1, re=0, busy=0, tx_done=0 throughout.
